// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter that shares one memory-controller request/return port
// between two requesters (A, B). Every issued transaction is recorded in a
// small outstanding table tagged by address; controller returns are matched
// against that table and routed back to the requester that owns the entry.
module mem_request_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    // requester A
    input  logic              a_req_valid,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_data,
    output logic              a_req_ready,
    output logic              a_rd_rsp_valid,
    output logic [ADDR_W-1:0] a_rd_rsp_addr,
    output logic [DATA_W-1:0] a_rd_rsp_data,
    output logic              a_wr_ack_valid,
    output logic [ADDR_W-1:0] a_wr_ack_addr,
    // requester B
    input  logic              b_req_valid,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_data,
    output logic              b_req_ready,
    output logic              b_rd_rsp_valid,
    output logic [ADDR_W-1:0] b_rd_rsp_addr,
    output logic [DATA_W-1:0] b_rd_rsp_data,
    output logic              b_wr_ack_valid,
    output logic [ADDR_W-1:0] b_wr_ack_addr,
    // memory controller
    output logic [ADDR_W-1:0] mc_wr_address,
    output logic              mc_wr_en,
    output logic [DATA_W-1:0] mc_wr_data,
    output logic [ADDR_W-1:0] mc_rd_address,
    output logic              mc_rd_en,
    input  logic [ADDR_W-1:0] mc_wr_ret_address,
    input  logic              mc_wr_ret_ack,
    input  logic [ADDR_W-1:0] mc_rd_ret_address,
    input  logic [DATA_W-1:0] mc_rd_ret_data,
    input  logic              mc_rd_ret_ack,
    // status
    output logic [2:0]        outstanding,
    output logic              err_unmatched
);

    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              owner;
        logic              is_write;
    } entry_t;

    entry_t            tbl_q [MAX_OUTSTANDING];
    entry_t            tbl_d [MAX_OUTSTANDING];
    logic [2:0]        count_q, count_d;
    logic              ptr_q;          // requester that wins a tie
    logic              err_q;

    logic              mc_rd_en_q, mc_wr_en_q;
    logic [ADDR_W-1:0] mc_rd_addr_q, mc_wr_addr_q;
    logic [DATA_W-1:0] mc_wr_data_q;

    // index 0 = requester A, index 1 = requester B
    logic [1:0]        rd_valid_q, wr_valid_q;
    logic [ADDR_W-1:0] rd_addr_q [2];
    logic [DATA_W-1:0] rd_data_q [2];
    logic [ADDR_W-1:0] wr_addr_q [2];

    logic              any_free, a_hit, b_hit, a_elig, b_elig;
    logic              grant_a, grant_b, grant;
    logic [IDX_W-1:0]  free_idx, rd_idx, wr_idx;
    logic              rd_match, wr_match;
    logic [1:0]        rd_pulse, wr_pulse;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Eligibility, grant and return matching, all from registered table state.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves one unassigned (no latches).
        any_free = 1'b0;
        free_idx = '0;
        a_hit    = 1'b0;
        b_hit    = 1'b0;
        rd_match = 1'b0;
        rd_idx   = '0;
        wr_match = 1'b0;
        wr_idx   = '0;
        // Descending scan so the lowest free index is the one left in free_idx.
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!tbl_q[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                if (tbl_q[i].addr == a_req_addr) a_hit = 1'b1;
                if (tbl_q[i].addr == b_req_addr) b_hit = 1'b1;
                if (!tbl_q[i].is_write && tbl_q[i].addr == mc_rd_ret_address) begin
                    rd_match = 1'b1;
                    rd_idx   = IDX_W'(i);
                end
                if (tbl_q[i].is_write && tbl_q[i].addr == mc_wr_ret_address) begin
                    wr_match = 1'b1;
                    wr_idx   = IDX_W'(i);
                end
            end
        end

        a_elig  = a_req_valid && any_free && !a_hit;
        b_elig  = b_req_valid && any_free && !b_hit;
        grant_a = a_elig && (!b_elig || ptr_q == OWNER_A);
        grant_b = b_elig && (!a_elig || ptr_q == OWNER_B);
        grant   = grant_a || grant_b;

        sel_we   = grant_b ? b_req_we   : a_req_we;
        sel_addr = grant_b ? b_req_addr : a_req_addr;
        sel_data = grant_b ? b_req_data : a_req_data;

        rd_pulse = 2'b00;
        wr_pulse = 2'b00;
        if (mc_rd_ret_ack && rd_match) rd_pulse[tbl_q[rd_idx].owner] = 1'b1;
        if (mc_wr_ret_ack && wr_match) wr_pulse[tbl_q[wr_idx].owner] = 1'b1;
    end

    // Next table contents: frees and the new allocation land on the same edge.
    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) tbl_d[i] = tbl_q[i];
        if (mc_rd_ret_ack && rd_match) tbl_d[rd_idx].valid = 1'b0;
        if (mc_wr_ret_ack && wr_match) tbl_d[wr_idx].valid = 1'b0;
        // A freed entry is valid in tbl_q, so it can never be the allocation target.
        if (grant) begin
            tbl_d[free_idx].valid    = 1'b1;
            tbl_d[free_idx].addr     = sel_addr;
            tbl_d[free_idx].owner    = grant_b;
            tbl_d[free_idx].is_write = sel_we;
        end
        count_d = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) count_d = count_d + 3'(tbl_d[i].valid);
    end

    // Table, pointer, controller issue and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the table is a few flops rather than a RAM, so it is reset with everything else.
            for (int i = 0; i < MAX_OUTSTANDING; i++) tbl_q[i] <= '0;
            count_q      <= '0;
            ptr_q        <= OWNER_A;
            err_q        <= 1'b0;
            mc_rd_en_q   <= 1'b0;
            mc_wr_en_q   <= 1'b0;
            mc_rd_addr_q <= '0;
            mc_wr_addr_q <= '0;
            mc_wr_data_q <= '0;
            rd_valid_q   <= 2'b00;
            wr_valid_q   <= 2'b00;
            for (int o = 0; o < 2; o++) begin
                rd_addr_q[o] <= '0;
                rd_data_q[o] <= '0;
                wr_addr_q[o] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            for (int i = 0; i < MAX_OUTSTANDING; i++) tbl_q[i] <= tbl_d[i];
            count_q <= count_d;
            if (grant) ptr_q <= grant_a ? OWNER_B : OWNER_A;
            if ((mc_rd_ret_ack && !rd_match) || (mc_wr_ret_ack && !wr_match)) err_q <= 1'b1;

            mc_rd_en_q <= grant && !sel_we;
            mc_wr_en_q <= grant && sel_we;
            if (grant && !sel_we) mc_rd_addr_q <= sel_addr;
            if (grant && sel_we) begin
                mc_wr_addr_q <= sel_addr;
                mc_wr_data_q <= sel_data;
            end

            rd_valid_q <= rd_pulse;
            wr_valid_q <= wr_pulse;
            for (int o = 0; o < 2; o++) begin
                if (rd_pulse[o]) begin
                    rd_addr_q[o] <= mc_rd_ret_address;
                    rd_data_q[o] <= mc_rd_ret_data;
                end
                if (wr_pulse[o]) wr_addr_q[o] <= mc_wr_ret_address;
            end
        end
    end

    assign a_req_ready    = grant_a;
    assign b_req_ready    = grant_b;
    assign a_rd_rsp_valid = rd_valid_q[0];
    assign a_rd_rsp_addr  = rd_addr_q[0];
    assign a_rd_rsp_data  = rd_data_q[0];
    assign a_wr_ack_valid = wr_valid_q[0];
    assign a_wr_ack_addr  = wr_addr_q[0];
    assign b_rd_rsp_valid = rd_valid_q[1];
    assign b_rd_rsp_addr  = rd_addr_q[1];
    assign b_rd_rsp_data  = rd_data_q[1];
    assign b_wr_ack_valid = wr_valid_q[1];
    assign b_wr_ack_addr  = wr_addr_q[1];
    assign mc_rd_en       = mc_rd_en_q;
    assign mc_rd_address  = mc_rd_addr_q;
    assign mc_wr_en       = mc_wr_en_q;
    assign mc_wr_address  = mc_wr_addr_q;
    assign mc_wr_data     = mc_wr_data_q;
    assign outstanding    = count_q;
    assign err_unmatched  = err_q;

endmodule
